usbfs_endp_tx: RTL and testbench

Device-to-host (IN) endpoint adapter for the full-speed USB device stack. Accepts a byte stream from user logic, buffers it in an internal FIFO, and fills the IN transactor's packet buffer one byte per cycle. It then presents the packet to the transactor and holds it until the transactor reports that the host has acknowledged it. It is the transmit-side counterpart of the OUT endpoint adapter and sits between user logic and the transactor's transmit buffer.

---
 rtl/usbfs_endp_tx_pkg.sv | 10 +
 rtl/fifoW1R1.sv | 46 ++++
 rtl/usbfs_endp_tx.sv | 72 +++++++
 tb/tb_usbfs_endp_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/usbfs_endp_tx_pkg.sv
// usbfs_endp_tx_pkg: shared USB endpoint types and parameter checks.
package usbfs_endp_tx_pkg;

    typedef enum logic [1:0] {IDLE, FILL, PRESENT} state_e;

    function automatic bit max_pkt_legal(int n);
        return n == 8 || n == 16 || n == 32 || n == 64;
    endfunction

endpackage

// File: rtl/fifoW1R1.sv
// fifoW1R1: single-clock FIFO, one write and one read port, head visible the cycle after a push.
module fifoW1R1 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             push, pop;

    assign o_ready = cnt_q != (AW+1)'(DEPTH);
    assign o_valid = cnt_q != '0;
    assign o_data  = mem_q[rd_q];
    assign push    = i_valid && o_ready;
    assign pop     = i_ready && o_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (i_cg) begin
            wr_q  <= wr_q + AW'(push);
            rd_q  <= rd_q + AW'(pop);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_cg && push) mem_q[wr_q] <= i_data;
    end

endmodule

// File: rtl/usbfs_endp_tx.sv
// usbfs_endp_tx: IN endpoint adapter; buffers a user byte stream and fills the transactor packet buffer.
module usbfs_endp_tx
    import usbfs_endp_tx_pkg::*;
#(
    parameter int MAX_PKT = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [7:0]                   i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic                         o_etValid,
    input  logic                         i_etReady,
    output logic                         o_etStall,
    output logic                         o_etWrEn,
    output logic [$clog2(MAX_PKT)-1:0]   o_etWrIdx,
    output logic [7:0]                   o_etWrByte,
    output logic [$clog2(MAX_PKT+1)-1:0] o_etWrNBytes
);
    localparam int NBYTES_W = $clog2(MAX_PKT + 1);
    localparam int IDX_W    = $clog2(MAX_PKT);
    localparam logic [NBYTES_W-1:0] FULL = NBYTES_W'(MAX_PKT);

    if (!max_pkt_legal(MAX_PKT)) begin : g_bad_max_pkt
        $error("usbfs_endp_tx: MAX_PKT must be 8, 16, 32 or 64");
    end

    state_e              state_q, state_d;
    logic [NBYTES_W-1:0] count_q, count_d;
    logic                fifo_valid;
    logic [7:0]          fifo_data;

    fifoW1R1 #(.WIDTH(8), .DEPTH(MAX_PKT)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_cg    (1'b1),
        .i_flush (1'b0),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (fifo_data),
        .o_valid (fifo_valid),
        .i_ready (o_etWrEn)
    );

    // A stream pause with a partial packet in the buffer closes it as a short packet.
    always_comb begin
        o_etWrEn = state_q == FILL && fifo_valid && count_q < FULL;
        count_d  = (state_q == PRESENT && i_etReady) ? '0 : count_q + NBYTES_W'(o_etWrEn);
        state_d  = state_q == IDLE    ? (fifo_valid ? FILL : IDLE)
                 : state_q == FILL    ? ((count_d == FULL || (!fifo_valid && count_q != '0)) ? PRESENT : FILL)
                 : state_q == PRESENT ? (i_etReady ? IDLE : PRESENT)
                 : IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign o_etValid    = state_q == PRESENT;
    assign o_etWrIdx    = count_q[IDX_W-1:0];
    assign o_etWrByte   = fifo_data;
    assign o_etWrNBytes = count_q;
    assign o_etStall    = 1'b0;

endmodule

// File: tb/tb_usbfs_endp_tx.sv
// tb_usbfs_endp_tx: randomized and directed checks of usbfs_endp_tx against a queue-based reference.
module tb_usbfs_endp_tx;
    localparam int MP = 8;

    logic       clk = 0;
    logic       i_rst = 1;
    logic [7:0] i_data = 0;
    logic       i_valid = 0;
    logic       i_etReady = 0;
    logic       o_ready, o_etValid, o_etStall, o_etWrEn;
    logic [2:0] o_etWrIdx;
    logic [7:0] o_etWrByte;
    logic [3:0] o_etWrNBytes;

    int tests = 0;
    int fails = 0;

    usbfs_endp_tx #(.MAX_PKT(MP)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_etValid    (o_etValid),
        .i_etReady    (i_etReady),
        .o_etStall    (o_etStall),
        .o_etWrEn     (o_etWrEn),
        .o_etWrIdx    (o_etWrIdx),
        .o_etWrByte   (o_etWrByte),
        .o_etWrNBytes (o_etWrNBytes)
    );

    always #5 clk = ~clk;

    // Reference: bytes waiting upstream, bytes already placed in the current packet,
    // and whether the endpoint is gathering a packet or offering it to the host.
    byte unsigned mq[$];
    int           pn = 0;
    bit           gathering = 0;
    bit           offering = 0;
    bit           chk_en = 0;
    logic [7:0]   pbuf [MP];

    function automatic bit e_wren();
        return gathering && mq.size() > 0 && pn < MP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (i_rst) begin
            mq.delete();
            pn = 0;
            gathering = 0;
            offering = 0;
            chk_en = 1;
        end else begin
            bit push, pop;
            push = i_valid && mq.size() < MP;
            pop = e_wren();
            if (!gathering && !offering) begin
                if (mq.size() > 0) gathering = 1;
            end else if (gathering) begin
                if (pn + int'(pop) == MP || (mq.size() == 0 && pn > 0)) begin
                    gathering = 0;
                    offering = 1;
                end
                pn += int'(pop);
            end else if (i_etReady) begin
                offering = 0;
                pn = 0;
            end
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(i_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", o_ready, mq.size() < MP);
            chk("etValid", o_etValid, offering);
            chk("etWrEn", o_etWrEn, e_wren());
            chk("etWrNBytes", o_etWrNBytes, pn);
            chk("etStall", o_etStall, 0);
            if (e_wren()) begin
                chk("etWrIdx", o_etWrIdx, pn % MP);
                chk("etWrByte", o_etWrByte, mq[0]);
            end
            if (o_etWrEn) pbuf[o_etWrIdx] = o_etWrByte;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        int k = 0;
        i_valid = 1;
        i_data = d;
        while (!o_ready && k < 200) begin
            tick();
            k++;
        end
        if (!o_ready) chk("push_timeout", 0, 1);
        tick();
        i_valid = 0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!o_etValid && k < 200) begin
            tick();
            k++;
        end
        chk(name, o_etValid, 1);
    endtask

    task automatic ack();
        i_etReady = 1;
        tick();
        i_etReady = 0;
    endtask

    initial begin
        int k;
        i_rst = 1;
        repeat (3) tick();
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_etValid, 0);
        chk("rst_wren", o_etWrEn, 0);
        chk("rst_idx", o_etWrIdx, 0);
        chk("rst_nbytes", o_etWrNBytes, 0);
        chk("rst_stall", o_etStall, 0);
        i_rst = 0;
        repeat (100) tick();
        chk("idle_valid", o_etValid, 0);

        for (int i = 0; i < 16; i++) push_byte(8'(i));
        wait_valid("pkt1_valid");
        chk("pkt1_nbytes", o_etWrNBytes, 8);
        chk("pkt1_b0", pbuf[0], 8'h00);
        chk("pkt1_b7", pbuf[7], 8'h07);
        ack();
        wait_valid("pkt2_valid");
        chk("pkt2_nbytes", o_etWrNBytes, 8);
        chk("pkt2_b0", pbuf[0], 8'h08);
        chk("pkt2_b7", pbuf[7], 8'h0F);
        ack();

        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        wait_valid("short_valid");
        chk("short_nbytes", o_etWrNBytes, 3);
        chk("short_b0", pbuf[0], 8'hA1);
        chk("short_b2", pbuf[2], 8'hA3);

        for (int i = 0; i < 8; i++) push_byte(8'hB0 + 8'(i));
        chk("bp_ready_low", o_ready, 0);
        chk("bp_nbytes_held", o_etWrNBytes, 3);
        ack();
        wait_valid("bp_valid");
        chk("bp_nbytes", o_etWrNBytes, 8);
        chk("bp_b0", pbuf[0], 8'hB0);
        chk("bp_b7", pbuf[7], 8'hB7);

        for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i));
        ack();
        k = 0;
        while (!(o_etWrEn && o_etWrIdx == 3'd4) && k < 200) begin
            tick();
            k++;
        end
        chk("mid_5th_write", o_etWrEn && o_etWrIdx == 3'd4, 1);
        i_rst = 1;
        tick();
        i_rst = 0;
        chk("mid_nbytes", o_etWrNBytes, 0);
        chk("mid_ready", o_ready, 1);
        chk("mid_wren", o_etWrEn, 0);
        chk("mid_valid", o_etValid, 0);
        repeat (30) tick();
        chk("mid_no_present", o_etValid, 0);

        for (int c = 0; c < 4000; c++) begin
            i_rst = ($urandom_range(0, 499) == 0);
            i_valid = ($urandom_range(0, 2) != 0);
            i_data = 8'($urandom);
            i_etReady = ($urandom_range(0, 3) == 0);
            tick();
        end
        i_rst = 0;
        i_valid = 0;
        i_etReady = 1;
        repeat (40) tick();
        chk("drain_ready", o_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
